dk_video_source: RTL
====================

// Module: dk_video_source
// PURPOSE
//  Raster source feeding the frame doubler's input port: emits a 256x224 CRT-order pixel stream
//  (level pixel clock, valid, RGB332) paced by a divided masterclk. Active pixels come from a
//  framebuffer read port or a built-in colour-bar pattern. After reset it starts in VBLANK, as the
//  doubler's input side requires.
// PARAMETERS
//  CLK_DIV   4    masterclk cycles per pixel; even, >=4. HALF = CLK_DIV/2
//  H_ACTIVE  256  active pixels per line
//  H_TOTAL   384  pixels per line incl. blanking
//  V_ACTIVE  224  active lines per frame
//  V_TOTAL   264  lines per frame incl. blanking
//  ADDR_W    16   framebuffer address width, $clog2(H_ACTIVE*V_ACTIVE)
// PORTS
//  masterclk    in   1       system clock, all logic rising-edge
//  rst          in   1       asynchronous, active-high reset
//  pattern_sel  in   1       1 = colour bars, 0 = framebuffer; sampled only at frame start
//  fb_rd        out  1       framebuffer read strobe, one cycle per active pixel
//  fb_addr      out  ADDR_W  read address = v*H_ACTIVE + h
//  fb_data      in   8       {b[7:6],g[5:3],r[2:0]}, valid the cycle after fb_rd
//  pix_clk      out  1       pixel clock level, high for HALF cycles, low for HALF cycles
//  pix_valid    out  1       current pixel is active
//  pix_r/pix_g  out  3/3     red/green
//  pix_b        out  2       blue
//  hblank       out  1       h >= H_ACTIVE
//  vblank       out  1       v >= V_ACTIVE
//  frame_start  out  1       one-cycle pulse when position becomes (0,0)
// BEHAVIOUR
//  - Reset values: pix_clk/pix_valid/fb_rd/frame_start=0, rgb=0, fb_addr=0, hblank=vblank=1.
//    Phase ph=0, position (h,v)=(0,V_ACTIVE), latched pattern select=0.
//  - Reset asserted mid-frame forces these values immediately, with no wait for a clock edge.
//  - Phase: ph advances 0..CLK_DIV-1 and wraps every cycle. All outputs are registered.
//  - pix_clk: set on the edge where ph becomes 0, cleared on the edge where ph becomes HALF.
//    It is therefore low after reset, and the first rise is CLK_DIV edges after release.
//  - Pixel boundary = edge where ph becomes HALF (falling pix_clk). On it:
//    * the position advances: h+1; at H_TOTAL-1, h=0 and v+1; at V_TOTAL-1, v=0.
//    * hblank, vblank, pix_valid (= !hblank && !vblank) and rgb update for the new position.
//    * rgb outputs are 0 when the new position is not valid.
//    Data stays stable for the whole high phase of pix_clk, so the receiver samples it on pix_clk high.
//  - Framebuffer fetch (pattern mode off):
//    * fb_rd=1 for the single cycle with ph==HALF-2, only if the next position is active.
//    * fb_addr = address of that next position; it holds its value when fb_rd=0.
//    * fb_data is captured on the boundary edge and split r=[2:0], g=[5:3], b=[7:6].
//    * No fetches are made during blanking. Address runs 0..H_ACTIVE*V_ACTIVE-1, then restarts at 0.
//  - Pattern mode: bar index k = h[7:5]; r={3{k[0]}}, g={3{k[1]}}, b={2{k[2]}}; fb_rd stays 0.
//  - pattern_sel is latched on the boundary edge that moves to (0,0). frame_start pulses on that edge.
//    A change mid-frame takes effect from the next frame.
//  - Frame length = H_TOTAL*V_TOTAL pixel periods. First active pixel comes
//    (V_TOTAL-V_ACTIVE)*H_TOTAL boundaries after reset.
// TESTING
//  1 Reset: rst pulsed mid-line -> outputs at reset values the same cycle. After release, the first
//    pix_clk rise is at edge 4 and the first boundary at edge 2 (CLK_DIV=4).
//  2 Timing: run 2 frames -> pix_clk period 4, high 2. Per frame: 57344 periods with pix_valid=1 and
//    101376 periods total. frame_start pulses are 405504 cycles apart.
//  3 Fetch: fb model returns addr[7:0]^addr[15:8] -> pixel (h=5,v=3) carries fb_addr 773 and
//    data 0x06. Exactly 57344 fb_rd pulses per frame, none while hblank|vblank.
//  4 Wrap: last active pixel (255,223) fetches addr 57343. The next fb_rd is addr 0 for (0,0) of
//    the next frame, after 40 lines plus 128 pixels of blanking.
//  5 Pattern: pattern_sel 0->1 mid-frame -> fb_rd continues until frame_start. Then fb_rd=0, and
//    h=32..63 gives r=7/g=0/b=0, h=224..255 gives 7/7/3.
//  6 Loopback: drive the frame doubler input (pix_clk/pix_valid/rgb) -> it writes exactly 57344
//    pixels per frame and its frame parity toggles once per source frame.

Source files
------------

// File: rtl/dk_video_source.sv
// Raster source: CRT-order RGB332 pixel stream with a level pixel clock, fed from a framebuffer or colour bars.
// Outputs are registered; the position advances on the falling pix_clk edge and data is stable while pix_clk is high.
module dk_video_source #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 256,
    parameter int H_TOTAL  = 384,
    parameter int V_ACTIVE = 224,
    parameter int V_TOTAL  = 264,
    parameter int ADDR_W   = 16
) (
    input  logic              masterclk,
    input  logic              rst,
    input  logic              pattern_sel,
    output logic              fb_rd,
    output logic [ADDR_W-1:0] fb_addr,
    input  logic [7:0]        fb_data,
    output logic              pix_clk,
    output logic              pix_valid,
    output logic [2:0]        pix_r,
    output logic [2:0]        pix_g,
    output logic [1:0]        pix_b,
    output logic              hblank,
    output logic              vblank,
    output logic              frame_start
);

    localparam int HALF = CLK_DIV / 2;
    localparam int PH_W = $clog2(CLK_DIV);
    localparam int H_W  = $clog2(H_TOTAL);
    localparam int V_W  = $clog2(V_TOTAL);

    localparam logic [PH_W-1:0] PH_LAST  = PH_W'(CLK_DIV - 1);
    localparam logic [PH_W-1:0] PH_HALF  = PH_W'(HALF);
    localparam logic [PH_W-1:0] PH_FETCH = PH_W'(HALF - 2);
    localparam logic [H_W-1:0]  H_LAST   = H_W'(H_TOTAL - 1);
    localparam logic [H_W-1:0]  H_ACT    = H_W'(H_ACTIVE);
    localparam logic [V_W-1:0]  V_LAST   = V_W'(V_TOTAL - 1);
    localparam logic [V_W-1:0]  V_ACT    = V_W'(V_ACTIVE);

    logic [PH_W-1:0]   ph_q, ph_d;
    logic [H_W-1:0]    h_q, h_d, h_n;
    logic [V_W-1:0]    v_q, v_d, v_n;
    logic              pat_q, pat_d;
    logic              fb_rd_q, fb_rd_d;
    logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
    logic              pix_clk_q, pix_clk_d;
    logic              pix_valid_q, pix_valid_d;
    logic [2:0]        pix_r_q, pix_r_d, pix_g_q, pix_g_d;
    logic [1:0]        pix_b_q, pix_b_d;
    logic              hblank_q, hblank_d, vblank_q, vblank_d;
    logic              frame_start_q, frame_start_d;
    logic              boundary, n_active;
    logic [2:0]        bar;

    always_comb begin
        ph_d     = (ph_q == PH_LAST) ? '0 : ph_q + PH_W'(1);
        boundary = (ph_d == PH_HALF);

        // Position that becomes current at the next boundary.
        if (h_q == H_LAST) begin
            h_n = '0;
            v_n = (v_q == V_LAST) ? '0 : v_q + V_W'(1);
        end else begin
            h_n = h_q + H_W'(1);
            v_n = v_q;
        end
        n_active = (h_n < H_ACT) && (v_n < V_ACT);
        bar      = h_n[7:5];

        h_d           = h_q;
        v_d           = v_q;
        pat_d         = pat_q;
        fb_rd_d       = 1'b0;
        fb_addr_d     = fb_addr_q;
        pix_clk_d     = pix_clk_q;
        pix_valid_d   = pix_valid_q;
        pix_r_d       = pix_r_q;
        pix_g_d       = pix_g_q;
        pix_b_d       = pix_b_q;
        hblank_d      = hblank_q;
        vblank_d      = vblank_q;
        frame_start_d = 1'b0;

        if (ph_d == '0) pix_clk_d = 1'b1;

        // Fetch lands on fb_data one cycle before the boundary that consumes it.
        if (ph_d == PH_FETCH && n_active && !pat_q) begin
            fb_rd_d   = 1'b1;
            fb_addr_d = ADDR_W'(v_n) * ADDR_W'(H_ACTIVE) + ADDR_W'(h_n);
        end

        if (boundary) begin
            pix_clk_d   = 1'b0;
            h_d         = h_n;
            v_d         = v_n;
            hblank_d    = (h_n >= H_ACT);
            vblank_d    = (v_n >= V_ACT);
            pix_valid_d = n_active;
            if (h_n == '0 && v_n == '0) begin
                pat_d         = pattern_sel;
                frame_start_d = 1'b1;
            end
            if (!n_active) begin
                pix_r_d = '0;
                pix_g_d = '0;
                pix_b_d = '0;
            end else if (pat_d) begin
                pix_r_d = {3{bar[0]}};
                pix_g_d = {3{bar[1]}};
                pix_b_d = {2{bar[2]}};
            end else begin
                pix_r_d = fb_data[2:0];
                pix_g_d = fb_data[5:3];
                pix_b_d = fb_data[7:6];
            end
        end
    end

    always_ff @(posedge masterclk or posedge rst) begin
        if (rst) begin
            ph_q          <= '0;
            h_q           <= '0;
            v_q           <= V_ACT;
            pat_q         <= 1'b0;
            fb_rd_q       <= 1'b0;
            fb_addr_q     <= '0;
            pix_clk_q     <= 1'b0;
            pix_valid_q   <= 1'b0;
            pix_r_q       <= '0;
            pix_g_q       <= '0;
            pix_b_q       <= '0;
            hblank_q      <= 1'b1;
            vblank_q      <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            ph_q          <= ph_d;
            h_q           <= h_d;
            v_q           <= v_d;
            pat_q         <= pat_d;
            fb_rd_q       <= fb_rd_d;
            fb_addr_q     <= fb_addr_d;
            pix_clk_q     <= pix_clk_d;
            pix_valid_q   <= pix_valid_d;
            pix_r_q       <= pix_r_d;
            pix_g_q       <= pix_g_d;
            pix_b_q       <= pix_b_d;
            hblank_q      <= hblank_d;
            vblank_q      <= vblank_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign fb_rd       = fb_rd_q;
    assign fb_addr     = fb_addr_q;
    assign pix_clk     = pix_clk_q;
    assign pix_valid   = pix_valid_q;
    assign pix_r       = pix_r_q;
    assign pix_g       = pix_g_q;
    assign pix_b       = pix_b_q;
    assign hblank      = hblank_q;
    assign vblank      = vblank_q;
    assign frame_start = frame_start_q;

endmodule
